machine_arbiter: RTL and testbench

MACHINE_ARBITER -- requirements
Module: machine_arbiter

---
 rtl/machine_arbiter.sv | 164 ++++++++++++++++
 tb/tb_machine_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/machine_arbiter.sv
// machine_arbiter: arbitrates one shared machine between two requesters.
// A winner is picked in IDLE, its operation word is latched onto m_on, and a
// one-cycle m_start is issued. The job runs while m_active is high; the block
// gives up if m_active never rises within the WAIT_ACT window. Completion is
// reported with a one-cycle done pulse (plus err on timeout).
//
// Build option: MACHINE_ARB_RR_EN selects round-robin arbitration (with a
// last-winner register); left undefined, requester 0 has fixed priority.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req       per-requester level request, held until done
//   req_on0   operation word of requester 0
//   req_on1   operation word of requester 1
//   m_active  busy flag from the machine control path
//   m_on      operation word driven to the control path (registered)
//   m_start   one-cycle start pulse (registered)
//   grant     one-hot machine owner, or 0 (registered)
//   done      one-cycle completion pulse per requester (registered)
//   err       one-cycle timeout flag, coincident with done (registered)
//   busy      high whenever the FSM is not in IDLE (registered)
module machine_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] req_on0,
  input  logic [1:0] req_on1,
  input  logic       m_active,
  output logic [1:0] m_on,
  output logic       m_start,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       err,
  output logic       busy
);

  localparam int unsigned CNT_W = 4;
  // Last WAIT_ACT count before giving up; the counter reaches 15 on that edge.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(14);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACT,
    RUN,
    FIN
  } state_t;

  state_t           state;
  logic             winner;
  logic [CNT_W-1:0] cnt;
  logic             tmo_flag;
  logic             pick_c;

`ifdef MACHINE_ARB_RR_EN
  logic last_win;

  // Round-robin pick: on a tie the requester that did not win last time wins.
  always_comb begin
    pick_c = 1'b0;
    if (req == 2'b11) begin
      pick_c = ~last_win;
    end else begin
      pick_c = req[1] & ~req[0];
    end
  end

  // Reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_win <= 1'b1;
    end else if (state == FIN) begin
      last_win <= winner;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it asks.
  always_comb begin
    pick_c = ~req[0];
  end
`endif

  // Main FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      winner   <= 1'b0;
      cnt      <= '0;
      tmo_flag <= 1'b0;
      m_on     <= '0;
      m_start  <= 1'b0;
      grant    <= '0;
      done     <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state   <= ISSUE;
            winner  <= pick_c;
            m_on    <= pick_c ? req_on1 : req_on0;
            grant   <= pick_c ? 2'b10 : 2'b01;
            m_start <= 1'b1;
            busy    <= 1'b1;
          end else begin
            m_on <= '0;
          end
        end

        ISSUE: begin
          state    <= WAIT_ACT;
          m_start  <= 1'b0;
          cnt      <= '0;
          tmo_flag <= 1'b0;
        end

        WAIT_ACT: begin
          if (m_active) begin
            state <= RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == TMO_LAST) begin
              state    <= FIN;
              tmo_flag <= 1'b1;
              done     <= winner ? 2'b10 : 2'b01;
              err      <= 1'b1;
            end
          end
        end

        RUN: begin
          if (!m_active) begin
            state <= FIN;
            done  <= winner ? 2'b10 : 2'b01;
            err   <= 1'b0;
          end
        end

        FIN: begin
          state    <= IDLE;
          tmo_flag <= 1'b0;
          m_on     <= '0;
          grant    <= '0;
          done     <= '0;
          err      <= 1'b0;
          busy     <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          m_on    <= '0;
          m_start <= 1'b0;
          grant   <= '0;
          done    <= '0;
          err     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_machine_arbiter.sv
// Directed self-checking bench for machine_arbiter.
module tb_machine_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] req_on0;
  logic [1:0] req_on1;
  logic       m_active;
  logic [1:0] m_on;
  logic       m_start;
  logic [1:0] grant;
  logic [1:0] done;
  logic       err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int waited;

  machine_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_on0  (req_on0),
    .req_on1  (req_on1),
    .m_active (m_active),
    .m_on     (m_on),
    .m_start  (m_start),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 8'(grant), 8'd0);
    chk({tag, "_start"}, 8'(m_start), 8'd0);
    chk({tag, "_done"}, 8'(done), 8'd0);
    chk({tag, "_err"}, 8'(err), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_m_on"}, 8'(m_on), 8'd0);
  endtask

  // One job: bounded wait for m_start, then m_active high for act_len cycles.
  task automatic job(input logic [1:0] eg, input logic [1:0] eon, input int act_len,
                     input bit drop, output int n_wait);
    n_wait = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_wait++;
      if (m_start) break;
    end
    chk("start_seen", 8'(m_start), 8'd1);
    chk("grant_issue", 8'(grant), 8'(eg));
    chk("m_on_issue", 8'(m_on), 8'(eon));
    chk("busy_issue", 8'(busy), 8'd1);
    tick();
    chk("start_single", 8'(m_start), 8'd0);
    m_active = 1'b1;
    for (int i = 0; i < act_len; i++) begin
      tick();
      if (drop && i == 1) begin
        req     = 2'b00;
        req_on0 = ~req_on0;
      end
      chk("m_on_run", 8'(m_on), 8'(eon));
      chk("grant_run", 8'(grant), 8'(eg));
      chk("done_run", 8'(done), 8'd0);
    end
    m_active = 1'b0;
    tick();
    chk("done_fin", 8'(done), 8'(eg));
    chk("err_fin", 8'(err), 8'd0);
    chk("grant_fin", 8'(grant), 8'(eg));
    chk("m_on_fin", 8'(m_on), 8'(eon));
  endtask

  initial begin
    rst      = 1'b1;
    req      = 2'b00;
    req_on0  = 2'b00;
    req_on1  = 2'b00;
    m_active = 1'b0;
    tick();
    tick();
    chk_quiet("reset");

    // Single job: grant/m_start one cycle after req, done one cycle after m_active falls.
    rst     = 1'b0;
    req     = 2'b01;
    req_on0 = 2'b10;
    tick();
    chk("single_grant", 8'(grant), 8'h01);
    chk("single_start", 8'(m_start), 8'd1);
    chk("single_m_on", 8'(m_on), 8'h2);
    tick();
    chk("single_start_low", 8'(m_start), 8'd0);
    chk("single_grant_wait", 8'(grant), 8'h01);
    tick();
    m_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("single_done_run", 8'(done), 8'd0);
      chk("single_m_on_run", 8'(m_on), 8'h2);
    end
    m_active = 1'b0;
    tick();
    chk("single_done", 8'(done), 8'h01);
    chk("single_err", 8'(err), 8'd0);
    chk("single_grant_fin", 8'(grant), 8'h01);
    req = 2'b00;
    tick();
    chk_quiet("single_idle");

    // Contention from reset.
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    req     = 2'b11;
    req_on0 = 2'b01;
    req_on1 = 2'b11;
    job(2'b01, 2'b01, 2, 1'b0, waited);
`ifdef MACHINE_ARB_RR_EN
    job(2'b10, 2'b11, 2, 1'b0, waited);
`else
    job(2'b01, 2'b01, 2, 1'b0, waited);
`endif
    job(2'b01, 2'b01, 2, 1'b0, waited);

    // Timeout: m_active stays low, done+err 16 cycles after m_start.
    req = 2'b10;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_start) break;
    end
    chk("tmo_start", 8'(m_start), 8'd1);
    chk("tmo_grant", 8'(grant), 8'h02);
    chk("tmo_m_on", 8'(m_on), 8'h3);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("tmo_done_early", 8'(done), 8'd0);
      chk("tmo_busy", 8'(busy), 8'd1);
    end
    tick();
    chk("tmo_done", 8'(done), 8'h02);
    chk("tmo_err", 8'(err), 8'd1);
    req = 2'b00;
    tick();
    chk_quiet("tmo_idle");

    // Request drop and operation-word change during RUN.
    req     = 2'b01;
    req_on0 = 2'b01;
    job(2'b01, 2'b01, 4, 1'b1, waited);
    tick();
    chk_quiet("drop_idle");
    tick();
    chk("drop_no_restart", 8'(m_start), 8'd0);

    // Reset in RUN aborts the job.
    req     = 2'b01;
    req_on0 = 2'b10;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_start) break;
    end
    chk("rstrun_start", 8'(m_start), 8'd1);
    tick();
    m_active = 1'b1;
    tick();
    tick();
    chk("rstrun_busy", 8'(busy), 8'd1);
    rst = 1'b1;
    #1;
    chk_quiet("rstrun_async");
    tick();
    chk_quiet("rstrun_held");
    rst      = 1'b0;
    m_active = 1'b0;
    job(2'b01, 2'b10, 2, 1'b0, waited);
    chk("rstrun_first_arb", 8'(waited), 8'd1);

    // Back-to-back with req held: one IDLE cycle between FIN and next m_start.
    job(2'b01, 2'b10, 3, 1'b0, waited);
    chk("b2b_gap", 8'(waited), 8'd2);
    job(2'b01, 2'b10, 1, 1'b0, waited);
    chk("b2b_gap2", 8'(waited), 8'd2);
    req = 2'b00;
    tick();
    tick();
    chk_quiet("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
